codec_init_seq: RTL and testbench

Power-up configuration sequencer for the WM8731 codec. It drives the I2C command side of codec_top (wr_i2c, i2c_packet, i2c_idle) and writes a fixed table of register settings in order: reset, line-in gains, headphone gains, analog and digital path, power, interface format, sampling, activate. The block raises done when the codec is ready for adc/dac streaming. It also raises error if the I2C controller stalls.

---
 rtl/codec_pkg.sv | 46 ++++
 rtl/codec_init_seq_if.sv | 9 +
 rtl/codec_init_seq.sv | 140 ++++++++++++++
 tb/tb_codec_init_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared WM8731 definitions: register addresses, sequencer states and the
// power-up register table used by codec_init_seq.
package codec_pkg;

  localparam logic [6:0] R_LLIN   = 7'd0;
  localparam logic [6:0] R_RLIN   = 7'd1;
  localparam logic [6:0] R_LHP    = 7'd2;
  localparam logic [6:0] R_RHP    = 7'd3;
  localparam logic [6:0] R_APATH  = 7'd4;
  localparam logic [6:0] R_DPATH  = 7'd5;
  localparam logic [6:0] R_PWR    = 7'd6;
  localparam logic [6:0] R_IFACE  = 7'd7;
  localparam logic [6:0] R_SRATE  = 7'd8;
  localparam logic [6:0] R_ACTIVE = 7'd9;
  localparam logic [6:0] R_RESET  = 7'd15;

  localparam int NUM_INIT_STEPS = 11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_GAP, ST_WAIT_IDLE, ST_DONE, ST_ERROR
  } state_e;

  // {reg[6:0], data[8:0]} for each power-up step; out-of-range returns 0
  function automatic logic [15:0] init_word(input logic [3:0] idx);
    logic [6:0] r;
    logic [8:0] d;
    r = '0;
    d = '0;
    case (idx)
      4'd0:  begin r = R_RESET;  d = 9'h000; end
      4'd1:  begin r = R_LLIN;   d = 9'h017; end
      4'd2:  begin r = R_RLIN;   d = 9'h017; end
      4'd3:  begin r = R_LHP;    d = 9'h079; end
      4'd4:  begin r = R_RHP;    d = 9'h079; end
      4'd5:  begin r = R_APATH;  d = 9'h012; end
      4'd6:  begin r = R_DPATH;  d = 9'h000; end
      4'd7:  begin r = R_PWR;    d = 9'h000; end
      4'd8:  begin r = R_IFACE;  d = 9'h001; end
      4'd9:  begin r = R_SRATE;  d = 9'h000; end
      4'd10: begin r = R_ACTIVE; d = 9'h001; end
      default: ;
    endcase
    return {r, d};
  endfunction

endpackage

// File: rtl/codec_init_seq_if.sv
// I2C command channel between the init sequencer (master) and codec_top (slave).
interface codec_init_seq_if;
  logic        wr_i2c;
  logic [23:0] i2c_packet;
  logic        i2c_idle;

  modport master (output wr_i2c, i2c_packet, input i2c_idle);
  modport slave  (input wr_i2c, i2c_packet, output i2c_idle);
endinterface

// File: rtl/codec_init_seq.sv
// WM8731 power-up sequencer: streams the init table to the I2C controller,
// one packet per idle window, with a per-write stall timeout.
module codec_init_seq
  import codec_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter bit         AUTO_START     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  codec_init_seq_if.master i2c,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       step
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_STEP = 4'(NUM_INIT_STEPS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    step_q, step_d;
  logic [23:0]   pkt_q, pkt_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          auto_q, auto_d;

  // One counter serves both the gap delay and the idle-wait timeout; it is
  // cleared whenever a state that uses it is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    pkt_d   = pkt_q;
    wr_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    auto_d  = auto_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start || auto_q) begin
          state_d = ST_ISSUE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          step_d  = '0;
          cnt_d   = '0;
          auto_d  = 1'b0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i2c.i2c_idle) begin
          wr_d    = 1'b1;
          pkt_d   = {DEV_ADDR, init_word(step_q)};
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_ERROR;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_WAIT_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (i2c.i2c_idle) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = ST_ISSUE;
            cnt_d   = '0;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_ERROR;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      pkt_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      pkt_q   <= pkt_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      auto_q  <= auto_d;
    end
  end

  assign i2c.wr_i2c     = wr_q;
  assign i2c.i2c_packet = pkt_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign step           = step_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: randomized I2C idle model, packet monitor and
// per-scenario checks against the expected WM8731 init table.
module tb_codec_init_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, error;
  logic [3:0] step;

  codec_init_seq_if i2c_bus();

  codec_init_seq #(.DEV_ADDR(8'h34), .GAP_CYCLES(16), .TIMEOUT_CYCLES(100), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .i2c(i2c_bus),
    .busy(busy), .done(done), .error(error), .step(step)
  );

  always #5 clk = ~clk;

  logic [23:0] EXP [11] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                            24'h340812, 24'h340A00, 24'h340C00, 24'h340E01, 24'h341000,
                            24'h341201};

  int n_cmp = 0;
  int n_bad = 0;

  // idle model modes: 0 drop-and-return, 1 stuck low, 2 never drops, 3 stuck after stuck_n writes
  int mode = 2;
  int stuck_n = 4;
  int ret_left = 0;
  int wr_seen = 0;
  int cyc = 0;

  logic [23:0] pk_q[$];
  int          pc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      ret_left = 0;
      wr_seen  = 0;
      i2c_bus.i2c_idle = (mode != 1);
    end else begin
      if (i2c_bus.wr_i2c) wr_seen++;
      case (mode)
        1: i2c_bus.i2c_idle = 1'b0;
        2: i2c_bus.i2c_idle = 1'b1;
        default: begin
          if (mode == 3 && wr_seen >= stuck_n) i2c_bus.i2c_idle = 1'b0;
          else if (i2c_bus.wr_i2c) begin
            i2c_bus.i2c_idle = 1'b0;
            ret_left = $urandom_range(60, 20);
          end else if (ret_left > 0) begin
            ret_left--;
            if (ret_left == 0) i2c_bus.i2c_idle = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      pk_q.delete();
      pc_q.delete();
    end else if (i2c_bus.wr_i2c) begin
      pk_q.push_back(i2c_bus.i2c_packet);
      pc_q.push_back(cyc);
    end
  end

  task automatic do_reset(input int m);
    @(negedge clk);
    mode  = m;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    @(negedge clk);
    mode  = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({i2c_bus.wr_i2c, i2c_bus.i2c_packet, busy, done, error, step} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset_state: wr=%b pkt=%h busy=%b done=%b err=%b step=%0d, want all 0",
               i2c_bus.wr_i2c, i2c_bus.i2c_packet, busy, done, error, step);
    end
    reset = 1'b0;
    wait_done(3000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL auto_done: done never rose, want 1"); end
    n_cmp++;
    if (pk_q.size() != 11) begin
      n_bad++; $display("FAIL auto_count: %0d pulses, want 11", pk_q.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_cmp++;
        if (pk_q[i] !== EXP[i]) begin
          n_bad++; $display("FAIL auto_pkt%0d: got %h, want %h", i, pk_q[i], EXP[i]);
        end
      end
      for (int i = 1; i < 11; i++) begin
        n_cmp++;
        if (pc_q[i] - pc_q[i-1] < 18) begin
          n_bad++; $display("FAIL auto_spacing%0d: got %0d, want >= 18", i, pc_q[i] - pc_q[i-1]);
        end
      end
    end
    n_cmp++;
    if ({done, busy, error, step} !== {1'b1, 1'b0, 1'b0, 4'd10}) begin
      n_bad++; $display("FAIL auto_final: done=%b busy=%b err=%b step=%0d, want 1 0 0 10",
                        done, busy, error, step);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t;
    do_reset(1);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (error) begin t = i + 1; break; end
    end
    n_cmp++;
    if (t < 99 || t > 103) begin
      n_bad++; $display("FAIL timeout_latency: error after %0d cycles, want about 101", t);
    end
    n_cmp++;
    if ({busy, step} !== 5'd0 || pk_q.size() != 0) begin
      n_bad++; $display("FAIL timeout_state: busy=%b step=%0d pulses=%0d, want 0 0 0",
                        busy, step, pk_q.size());
    end
    mode = 2;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, error} !== 2'b10) begin
      n_bad++; $display("FAIL timeout_rerun_start: busy=%b err=%b, want 1 0", busy, error);
    end
    wait_done(3000, ok);
    n_cmp++;
    if (!ok || error !== 1'b0 || pk_q.size() != 11) begin
      n_bad++; $display("FAIL timeout_rerun: done=%b err=%b pulses=%0d, want 1 0 11",
                        done, error, pk_q.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_cmp++;
        if (pk_q[i] !== EXP[i]) begin
          n_bad++; $display("FAIL rerun_pkt%0d: got %h, want %h", i, pk_q[i], EXP[i]);
        end
      end
    end
  endtask

  task automatic test_stuck_mid();
    bit seen;
    stuck_n = 4;
    do_reset(3);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (error) begin seen = 1'b1; break; end
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (!seen || error !== 1'b1 || busy !== 1'b0 || step !== 4'd3) begin
      n_bad++; $display("FAIL stuck_state: err=%b busy=%b step=%0d, want 1 0 3", error, busy, step);
    end
    n_cmp++;
    if (pk_q.size() != 4) begin
      n_bad++; $display("FAIL stuck_pulses: got %0d, want 4", pk_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n_old;
    do_reset(0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pk_q.size() == 7) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_reach_step6: pulses=%0d, want 7", pk_q.size()); end
    repeat ($urandom_range(10, 3)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({i2c_bus.wr_i2c, i2c_bus.i2c_packet, busy, done, error, step} !== 33'd0) begin
      n_bad++;
      $display("FAIL mid_reset_state: wr=%b pkt=%h busy=%b done=%b err=%b step=%0d, want all 0",
               i2c_bus.wr_i2c, i2c_bus.i2c_packet, busy, done, error, step);
    end
    repeat (2) @(negedge clk);
    n_old = pk_q.size();
    reset = 1'b0;
    wait_done(3000, ok);
    n_cmp++;
    if (!ok || n_old != 0 || pk_q.size() != 11) begin
      n_bad++; $display("FAIL mid_restart: done=%b pulses=%0d, want 1 11", done, pk_q.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_cmp++;
        if (pk_q[i] !== EXP[i]) begin
          n_bad++; $display("FAIL mid_pkt%0d: got %h, want %h", i, pk_q[i], EXP[i]);
        end
      end
    end
  endtask

  task automatic test_restart();
    bit ok;
    int base;
    base = pk_q.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_bad++; $display("FAIL restart_start: busy=%b done=%b, want 1 0", busy, done);
    end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pk_q.size() == base + 3) begin ok = 1'b1; break; end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (!ok || busy !== 1'b1 || step > 4'd3) begin
      n_bad++; $display("FAIL restart_ignored: busy=%b step=%0d, want 1 <=3", busy, step);
    end
    wait_done(3000, ok);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (!ok || pk_q.size() - base != 11) begin
      n_bad++; $display("FAIL restart_count: pulses=%0d, want 11", pk_q.size() - base);
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_cmp++;
        if (pk_q[base+i] !== EXP[i]) begin
          n_bad++; $display("FAIL restart_pkt%0d: got %h, want %h", i, pk_q[base+i], EXP[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset(2);
    wait_done(3000, ok);
    n_cmp++;
    if (!ok || pk_q.size() != 11) begin
      n_bad++; $display("FAIL b2b_count: done=%b pulses=%0d, want 1 11", done, pk_q.size());
    end else begin
      for (int i = 1; i < 11; i++) begin
        n_cmp++;
        if (pc_q[i] - pc_q[i-1] != 18) begin
          n_bad++; $display("FAIL b2b_spacing%0d: got %0d, want 18", i, pc_q[i] - pc_q[i-1]);
        end
      end
    end
    n_cmp++;
    if (i2c_bus.i2c_packet !== 24'h341201) begin
      n_bad++; $display("FAIL b2b_pkt_hold: got %h, want 341201", i2c_bus.i2c_packet);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_timeout();
    test_stuck_mid();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
